// File: rtl/sr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sr_lock_arbiter
// Purpose  : Round-robin arbiter that shares one external cross-coupled NAND SR
//            latch, used as a hardware lock flag, between N_REQ requesters.
//            Drives timed active-low set/reset pulses and confirms each
//            transition by sampling the latch's Q/Qbar readback.
// Options  : define SR_LOCK_ARB_HOLD_TIMEOUT_EN to bound ownership to
//            HOLD_MAX cycles. A preempted requester must then drop its request
//            before it can win again.
// Revision : 1.0 - initial release
// ============================================================================
module sr_lock_arbiter #(
  parameter int N_REQ         = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int HOLD_MAX      = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_REQ-1:0] req,
  input  logic             latch_q,
  input  logic             latch_qbar,
  output logic [N_REQ-1:0] grant,
  output logic             latch_sbar,
  output logic             latch_rbar,
  output logic             busy,
  output logic             err
);

  localparam int c_MAX_PS  = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int c_MAX_CNT = (c_MAX_PS > HOLD_MAX) ? c_MAX_PS : HOLD_MAX;
  localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
  localparam int c_PTR_W   = $clog2(N_REQ);

  localparam logic [c_CNT_W-1:0] c_PULSE_LAST  = c_CNT_W'(PULSE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_INIT_CLR = 4'd0,
    S_INIT_W   = 4'd1,
    S_IDLE     = 4'd2,
    S_SET_P    = 4'd3,
    S_SET_W    = 4'd4,
    S_OWNED    = 4'd5,
    S_CLR_P    = 4'd6,
    S_CLR_W    = 4'd7,
    S_FAULT    = 4'd8
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_PTR_W-1:0]   r_owner;
  logic [c_PTR_W-1:0]   w_owner_next;
  logic [c_PTR_W-1:0]   r_rr_ptr;
  logic [c_PTR_W-1:0]   w_ptr_next;
  logic [c_PTR_W-1:0]   w_owner_inc;
  logic [N_REQ-1:0]     w_eligible;
  logic [N_REQ-1:0]     w_owner_oh;
  logic                 w_found;
  logic [c_PTR_W-1:0]   w_pick;
  int                   w_idx;
  logic                 w_latch_set;
  logic                 w_latch_clr;
  logic [N_REQ-1:0]     w_grant_d;
  logic                 w_sbar_d;
  logic                 w_rbar_d;
  logic                 w_busy_d;
  logic                 w_err_d;

  assign w_owner_inc = (r_owner == c_PTR_W'(N_REQ - 1)) ? '0 : r_owner + c_PTR_W'(1);
  assign w_owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_latch_set = latch_q & ~latch_qbar;
  assign w_latch_clr = ~latch_q & latch_qbar;

`ifdef SR_LOCK_ARB_HOLD_TIMEOUT_EN
  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_MAX - 1);

  logic [N_REQ-1:0] r_mask;
  logic             w_timeout;

  assign w_eligible = req & ~r_mask;

  // A preempted requester stays masked until it lets its request fall.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mask <= '0;
    end else begin
      r_mask <= (r_mask & req) | (w_timeout ? w_owner_oh : '0);
    end
  end
`else
  assign w_eligible = req;
`endif

  // Round-robin pick: lowest offset from rr_ptr wins, so scan downward and let
  // later (closer) hits overwrite earlier ones.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (w_eligible[w_idx[c_PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[c_PTR_W-1:0];
      end
    end
  end

  // Next-state selection and Moore decode of the outputs from the current state.
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_ptr_next   = r_rr_ptr;
`ifdef SR_LOCK_ARB_HOLD_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      S_INIT_CLR: if (r_cnt == c_PULSE_LAST) w_state_next = S_INIT_W;
      S_INIT_W: begin
        if (r_cnt == c_SETTLE_LAST) w_state_next = w_latch_clr ? S_IDLE : S_FAULT;
      end
      S_IDLE: begin
        if (w_found) begin
          w_owner_next = w_pick;
          w_state_next = S_SET_P;
        end
      end
      S_SET_P: if (r_cnt == c_PULSE_LAST) w_state_next = S_SET_W;
      S_SET_W: begin
        if (r_cnt == c_SETTLE_LAST) begin
          if (!w_latch_set) begin
            w_state_next = S_FAULT;
          end else if (req[r_owner]) begin
            w_state_next = S_OWNED;
          end else begin
            // Requester gave up while the lock was being taken: release it
            // without ever granting, but still rotate priority.
            w_state_next = S_CLR_P;
            w_ptr_next   = w_owner_inc;
          end
        end
      end
      S_OWNED: begin
        if (!req[r_owner]) begin
          w_state_next = S_CLR_P;
          w_ptr_next   = w_owner_inc;
        end
`ifdef SR_LOCK_ARB_HOLD_TIMEOUT_EN
        else if (r_cnt == c_HOLD_LAST) begin
          w_state_next = S_CLR_P;
          w_ptr_next   = w_owner_inc;
          w_timeout    = 1'b1;
        end
`endif
      end
      S_CLR_P: if (r_cnt == c_PULSE_LAST) w_state_next = S_CLR_W;
      S_CLR_W: begin
        if (r_cnt == c_SETTLE_LAST) w_state_next = w_latch_clr ? S_IDLE : S_FAULT;
      end
      S_FAULT: w_state_next = S_FAULT;
      default: w_state_next = S_FAULT;
    endcase

    w_grant_d = (r_state == S_OWNED) ? w_owner_oh : '0;
    w_sbar_d  = (r_state != S_SET_P);
    w_rbar_d  = (r_state != S_INIT_CLR) && (r_state != S_CLR_P);
    w_busy_d  = (r_state != S_IDLE) && (r_state != S_FAULT);
    w_err_d   = (r_state == S_FAULT);
  end

  // State, shared pulse/wait/hold counter (cleared on every state entry) and
  // registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_INIT_CLR;
      r_cnt      <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      grant      <= '0;
      latch_sbar <= 1'b1;
      latch_rbar <= 1'b1;
      busy       <= 1'b1;
      err        <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= (w_state_next != r_state) ? '0 : r_cnt + c_CNT_W'(1);
      r_owner    <= w_owner_next;
      r_rr_ptr   <= w_ptr_next;
      grant      <= w_grant_d;
      latch_sbar <= w_sbar_d;
      latch_rbar <= w_rbar_d;
      busy       <= w_busy_d;
      err        <= w_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_lock_arbiter
// Purpose  : Self-checking bench for sr_lock_arbiter with a behavioural NAND
//            latch and a latency-level reference model of the arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_lock_arbiter;

  localparam int N = 4;

  logic         CLK   = 1'b0;
  logic         RESET = 1'b0;
  logic [N-1:0] req   = '0;
  logic         latch_q;
  logic         latch_qbar;
  logic [N-1:0] grant;
  logic         latch_sbar;
  logic         latch_rbar;
  logic         busy;
  logic         err;

  logic lq        = 1'b1;
  logic stuck_en  = 1'b0;
  logic stuck_val = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int ptr_m = 0;

  sr_lock_arbiter dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .req        (req),
    .latch_q    (latch_q),
    .latch_qbar (latch_qbar),
    .grant      (grant),
    .latch_sbar (latch_sbar),
    .latch_rbar (latch_rbar),
    .busy       (busy),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  // Behavioural NAND latch: low set wins, low reset clears, otherwise hold.
  always @(latch_sbar or latch_rbar) begin
    if (!latch_sbar)      lq = 1'b1;
    else if (!latch_rbar) lq = 1'b0;
  end

  assign latch_q    = stuck_en ? stuck_val  : lq;
  assign latch_qbar = stuck_en ? ~stuck_val : ~lq;

  function automatic logic [N-1:0] oh(int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Advance one clock; outputs are then stable and inputs may be driven.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    req = '0; RESET = 1'b1;
    tick();
    RESET = 1'b0;
    n_vec++;
    if (grant !== '0 || latch_sbar !== 1'b1 || latch_rbar !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got grant=%b sbar=%b rbar=%b err=%b want 0000 1 1 0",
               grant, latch_sbar, latch_rbar, err);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_vec++;
      if (latch_rbar !== !(k == 1 || k == 2) || latch_sbar !== 1'b1) begin
        n_bad++;
        $display("FAIL init_pulse k=%0d: got rbar=%b sbar=%b want rbar=%b sbar=1",
                 k, latch_rbar, latch_sbar, !(k == 1 || k == 2));
      end
    end
    n_vec++;
    if (busy !== 1'b0 || err !== 1'b0 || latch_q !== 1'b0) begin
      n_bad++;
      $display("FAIL init_done: got busy=%b err=%b q=%b want 0 0 0", busy, err, latch_q);
    end
    ptr_m = 0;
  endtask

  task automatic test_single_request();
    req = 4'b0001;
    tick();
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_vec++;
      if (latch_sbar !== !(k == 1 || k == 2) || grant !== ((k >= 5) ? 4'b0001 : 4'b0000)) begin
        n_bad++;
        $display("FAIL acquire k=%0d: got sbar=%b grant=%b want sbar=%b grant=%b", k,
                 latch_sbar, grant, !(k == 1 || k == 2), (k >= 5) ? 4'b0001 : 4'b0000);
      end
    end
    req = 4'b0000;
    for (int k = 0; k <= 5; k++) begin
      tick();
      n_vec++;
      if (grant !== ((k == 0) ? 4'b0001 : 4'b0000) || latch_rbar !== !(k == 1 || k == 2) ||
          busy !== (k < 5)) begin
        n_bad++;
        $display("FAIL release u+%0d: got grant=%b rbar=%b busy=%b want %b %b %b", k, grant,
                 latch_rbar, busy, (k == 0) ? 4'b0001 : 4'b0000, !(k == 1 || k == 2), k < 5);
      end
    end
    ptr_m = 1;
  endtask

  task automatic test_round_robin();
    int w;
    int idx;
    RESET = 1'b1; tick(); RESET = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      idx = g % N;
      w = 0;
      while (grant == '0 && w < 20) begin
        tick();
        w++;
        n_vec++;
        if (!latch_sbar && !latch_rbar) begin
          n_bad++;
          $display("FAIL rr_forbidden: got sbar=0 rbar=0 want not both low");
        end
      end
      for (int h = 0; h < 3; h++) begin
        n_vec++;
        if (grant !== oh(idx)) begin
          n_bad++;
          $display("FAIL rr_grant g=%0d h=%0d: got %b want %b", g, h, grant, oh(idx));
        end
        if (h < 2) tick();
      end
      req[idx] = 1'b0;
      tick(); tick();
      if (g < 4) req[idx] = 1'b1;
      else       req = '0;
    end
    w = 0;
    while (busy !== 1'b0 && w < 10) begin tick(); w++; end
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rr_idle: got busy=%b want 0", busy);
    end
    ptr_m = 1;
  endtask

  task automatic test_early_release();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_vec++;
      if (grant !== '0 || latch_sbar !== !(k == 1 || k == 2) ||
          latch_rbar !== !(k == 5 || k == 6) || busy !== (k < 9)) begin
        n_bad++;
        $display("FAIL early k=%0d: got grant=%b sbar=%b rbar=%b busy=%b want 0000 %b %b %b",
                 k, grant, latch_sbar, latch_rbar, busy, !(k == 1 || k == 2),
                 !(k == 5 || k == 6), k < 9);
      end
    end
    ptr_m = 3;
    req = 4'b0011;
    tick();
    for (int k = 1; k <= 5; k++) tick();
    n_vec++;
    if (grant !== oh(rr_pick(4'b0011, ptr_m))) begin
      n_bad++;
      $display("FAIL early_ptr: got %b want %b", grant, oh(rr_pick(4'b0011, ptr_m)));
    end
    ptr_m = (rr_pick(4'b0011, ptr_m) + 1) % N;
    req = 4'b0000;
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_random();
    logic [N-1:0] cur;
    int owner;
    int hold;
    int nb;
    for (int round = 0; round < 12; round++) begin
      cur = N'($urandom_range(1, 15));
      req = cur;
      tick();
      while (cur != '0) begin
        n_vec++;
        if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL rnd_idle_sample: got busy=%b want 0", busy);
        end
        owner = rr_pick(cur, ptr_m);
        hold  = $urandom_range(1, 5);
        for (int k = 1; k <= 4 + hold; k++) begin
          tick();
          n_vec++;
          if (grant !== ((k >= 5) ? oh(owner) : '0) || busy !== 1'b1 ||
              (!latch_sbar && !latch_rbar) || err !== 1'b0) begin
            n_bad++;
            $display("FAIL rnd_own r=%0d k=%0d: got grant=%b busy=%b sbar=%b rbar=%b want %b 1",
                     round, k, grant, busy, latch_sbar, latch_rbar,
                     (k >= 5) ? oh(owner) : '0);
          end
        end
        cur[owner] = 1'b0;
        nb = $urandom_range(0, N - 1);
        if ($urandom_range(0, 1) == 1 && nb != owner) cur[nb] = 1'b1;
        req = cur;
        for (int k = 1; k <= 5; k++) begin
          tick();
          n_vec++;
          if (grant !== ((k == 1) ? oh(owner) : '0) || busy !== 1'b1 ||
              (!latch_sbar && !latch_rbar)) begin
            n_bad++;
            $display("FAIL rnd_rel r=%0d k=%0d: got grant=%b busy=%b want %b 1", round, k,
                     grant, busy, (k == 1) ? oh(owner) : '0);
          end
        end
        ptr_m = (owner + 1) % N;
        tick();
      end
      n_vec++;
      if (busy !== 1'b0 || grant !== '0) begin
        n_bad++;
        $display("FAIL rnd_end r=%0d: got busy=%b grant=%b want 0 0000", round, busy, grant);
      end
    end
  endtask

  task automatic test_fault();
    stuck_en = 1'b1; stuck_val = 1'b0;
    req = 4'b0001;
    tick();
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_vec++;
      if (grant !== '0 || err !== (k >= 5) || (k >= 5 && (busy !== 1'b0 ||
          latch_sbar !== 1'b1 || latch_rbar !== 1'b1))) begin
        n_bad++;
        $display("FAIL fault k=%0d: got grant=%b err=%b busy=%b sbar=%b rbar=%b", k, grant,
                 err, busy, latch_sbar, latch_rbar);
      end
    end
    req = 4'b0000;
    RESET = 1'b1; tick(); RESET = 1'b0;
    n_vec++;
    if (err !== 1'b0 || grant !== '0) begin
      n_bad++;
      $display("FAIL fault_reset: got err=%b grant=%b want 0 0000", err, grant);
    end
    tick();
    n_vec++;
    if (latch_rbar !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL fault_reinit: got rbar=%b busy=%b want 0 1", latch_rbar, busy);
    end
    stuck_en = 1'b0;
    for (int k = 2; k <= 5; k++) tick();
    n_vec++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_recover: got busy=%b err=%b want 0 0", busy, err);
    end
    ptr_m = 0;
  endtask

`ifdef SR_LOCK_ARB_HOLD_TIMEOUT_EN
  task automatic test_hold_timeout();
    int g0;
    RESET = 1'b1; tick(); RESET = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    g0 = 0;
    req = 4'b0011;
    tick();
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (grant == 4'b0001) g0++;
      n_vec++;
      if (grant !== ((k >= 5 && k <= 20) ? 4'b0001 : (k >= 30) ? 4'b0010 : 4'b0000)) begin
        n_bad++;
        $display("FAIL hold k=%0d: got %b want %b", k, grant,
                 (k >= 5 && k <= 20) ? 4'b0001 : (k >= 30) ? 4'b0010 : 4'b0000);
      end
    end
    n_vec++;
    if (g0 != 16) begin
      n_bad++;
      $display("FAIL hold_len: got %0d cycles want 16", g0);
    end
    req = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_vec++;
      if (grant !== ((k == 1) ? 4'b0010 : 4'b0000)) begin
        n_bad++;
        $display("FAIL hold_masked k=%0d: got %b want %b", k, grant,
                 (k == 1) ? 4'b0010 : 4'b0000);
      end
    end
    req = 4'b0000; tick();
    req = 4'b0001; tick();
    for (int k = 1; k <= 5; k++) tick();
    n_vec++;
    if (grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL hold_regrant: got %b want 0001", grant);
    end
    req = 4'b0000;
    for (int k = 0; k < 6; k++) tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_early_release();
    test_random();
    test_fault();
`ifdef SR_LOCK_ARB_HOLD_TIMEOUT_EN
    test_hold_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
